conv_seq_ctrl: RTL and testbench

- Sequencer for the 128x32 pipelined convolution datapath. Controls the x sliding-window shift memory and the arithmetic pipeline enable.
- Fills the x window, then waits for the filter memory to fill. It then streams one window per cycle through a PLINE_STAGES-deep pipeline, with AXI-stream style backpressure on the y output.
- Issues a one-cycle conv_done pulse once all X_SIZE-F_SIZE+1 outputs have been transferred.

---
 rtl/conv_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl
//   Sequencer for the pipelined convolution datapath. It fills the x
//   sliding-window shift memory, waits for the filter memory to fill, then
//   streams one window per cycle through a PLINE_STAGES-deep arithmetic
//   pipeline. The y output has AXI-stream style valid/ready backpressure.
//   A one-cycle conv_done pulse follows the final y handshake.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   s_valid_x       in   x input valid
//   s_ready_x       out  x input ready
//   xmem_wr_en      out  shift-in strobe to the x window (s_valid_x && s_ready_x)
//   xmem_full       out  window holds F_SIZE samples (WAIT_F and RUN)
//   fmem_full       in   filter memory holds F_SIZE taps
//   conv_start      out  high in RUN
//   en_pline_stages out  pipeline advance enable
//   m_valid         out  y output valid
//   m_ready         in   y output ready
//   conv_done       out  one-cycle pulse after the final y handshake
// -----------------------------------------------------------------------------
module conv_seq_ctrl #(
    parameter int X_SIZE       = 128,
    parameter int F_SIZE       = 32,
    parameter int PLINE_STAGES = 3,
    parameter int CNT_WIDTH    = $clog2(X_SIZE) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic s_valid_x,
    output logic s_ready_x,
    output logic xmem_wr_en,
    output logic xmem_full,
    input  logic fmem_full,
    output logic conv_start,
    output logic en_pline_stages,
    output logic m_valid,
    input  logic m_ready,
    output logic conv_done
);

    localparam logic [CNT_WIDTH-1:0] C_ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_X_SIZE    = CNT_WIDTH'(X_SIZE);
    localparam logic [CNT_WIDTH-1:0] C_FILL_LAST = CNT_WIDTH'(F_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] C_OUT_LAST  = CNT_WIDTH'(X_SIZE - F_SIZE);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_WAIT_F = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_WIDTH-1:0]    r_x_cnt;
    logic [CNT_WIDTH-1:0]    r_y_cnt;
    logic [PLINE_STAGES-1:0] r_vld;
    logic                    r_fresh;   // an un-injected window sits in xmem
    logic                    w_inject;
    logic                    w_y_hs;

    assign m_valid = r_vld[PLINE_STAGES-1];
    assign w_y_hs  = m_valid & m_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and control outputs.
    always_comb begin
        w_state_next    = r_state;
        s_ready_x       = 1'b0;
        en_pline_stages = 1'b1;
        xmem_full       = 1'b0;
        conv_start      = 1'b0;
        conv_done       = 1'b0;
        w_inject        = 1'b0;
        case (r_state)
            ST_FILL: begin
                s_ready_x = 1'b1;
                if (s_valid_x && (r_x_cnt == C_FILL_LAST)) begin
                    w_state_next = ST_WAIT_F;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_WAIT_F: begin
                xmem_full = 1'b1;
                if (fmem_full) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_WAIT_F;
                end
            end
            ST_RUN: begin
                xmem_full       = 1'b1;
                conv_start      = 1'b1;
                // A stalled output slot freezes the whole pipeline.
                en_pline_stages = ~m_valid | m_ready;
                s_ready_x       = en_pline_stages & (r_x_cnt < C_X_SIZE);
                w_inject        = r_fresh & en_pline_stages;
                if (w_y_hs && (r_y_cnt == C_OUT_LAST)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                conv_done    = 1'b1;
                w_state_next = ST_FILL;
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
        xmem_wr_en = s_valid_x & s_ready_x;
    end

    // Counters, valid pipeline and fresh-window flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_vld   <= '0;
            r_fresh <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (xmem_wr_en) begin
                        r_x_cnt <= r_x_cnt + C_ONE;
                    end
                    r_y_cnt <= '0;
                    r_vld   <= '0;
                    r_fresh <= 1'b0;
                end
                ST_WAIT_F: begin
                    r_vld   <= '0;
                    // The complete initial window is ready as soon as RUN starts.
                    r_fresh <= fmem_full;
                end
                ST_RUN: begin
                    if (xmem_wr_en) begin
                        r_x_cnt <= r_x_cnt + C_ONE;
                    end
                    if (w_y_hs) begin
                        r_y_cnt <= r_y_cnt + C_ONE;
                    end
                    if (w_state_next == ST_DONE) begin
                        r_vld   <= '0;
                        r_fresh <= 1'b0;
                    end else begin
                        if (en_pline_stages) begin
                            r_vld <= {r_vld[PLINE_STAGES-2:0], w_inject};
                        end
                        // Each shift exposes a new window; a stall keeps the pending one.
                        r_fresh <= xmem_wr_en | (r_fresh & ~en_pline_stages);
                    end
                end
                ST_DONE: begin
                    r_x_cnt <= '0;
                    r_y_cnt <= '0;
                    r_vld   <= '0;
                    r_fresh <= 1'b0;
                end
                default: begin
                    r_x_cnt <= '0;
                    r_y_cnt <= '0;
                    r_vld   <= '0;
                    r_fresh <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_seq_ctrl
//   Directed self-checking bench for conv_seq_ctrl with default parameters
//   (X_SIZE=128, F_SIZE=32, PLINE_STAGES=3, 97 outputs per vector).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1 time unit after that.
// -----------------------------------------------------------------------------
module tb_conv_seq_ctrl;

    logic clk;
    logic reset;
    logic s_valid_x;
    logic s_ready_x;
    logic xmem_wr_en;
    logic xmem_full;
    logic fmem_full;
    logic conv_start;
    logic en_pline_stages;
    logic m_valid;
    logic m_ready;
    logic conv_done;

    int checks;
    int errors;

    // Per-run measurements filled by run_vec.
    int g_acc;
    int g_hs;
    int g_done_cnt;
    int g_run_entry;
    int g_first_mv;
    int g_last_hs;
    int g_stall_viol;
    int g_acc_not_en;
    int g_done_viol;
    int g_wait_viol;
    int g_frise;
    int g_done_cyc [0:1];
    int g_hs_at_done [0:1];
    bit mv_h  [0:2047];
    bit acc_h [0:2047];

    conv_seq_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid_x       (s_valid_x),
        .s_ready_x       (s_ready_x),
        .xmem_wr_en      (xmem_wr_en),
        .xmem_full       (xmem_full),
        .fmem_full       (fmem_full),
        .conv_start      (conv_start),
        .en_pline_stages (en_pline_stages),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .conv_done       (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset     = 1'b1;
        s_valid_x = 1'b0;
        m_ready   = 1'b0;
        fmem_full = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one or more vectors and records what the DUT did, cycle by cycle.
    // vmode 0: s_valid_x always 1, 1: 30% duty. rmode 0: m_ready=1, 1: 1,0,0,1.
    // fwait 0: fmem_full always 1, else held 0 for fwait WAIT_F cycles.
    task automatic run_vec(input int vmode, input int rmode, input int fwait,
                           input int n_done, input int budget);
        int wait_cnt;
        bit prev_stall;
        bit in_wait;
        int c;
        g_acc = 0; g_hs = 0; g_done_cnt = 0; g_run_entry = -1; g_first_mv = -1;
        g_last_hs = -1; g_stall_viol = 0; g_acc_not_en = 0; g_done_viol = 0;
        g_wait_viol = 0; g_frise = -1;
        g_done_cyc[0] = -1; g_done_cyc[1] = -1;
        g_hs_at_done[0] = -1; g_hs_at_done[1] = -1;
        wait_cnt = 0; prev_stall = 1'b0; c = 0;
        while (c < budget && g_done_cnt < n_done) begin
            in_wait   = xmem_full && !conv_start;
            s_valid_x = (vmode == 0) ? 1'b1 : (((c * 7) % 10) < 3);
            m_ready   = (rmode == 0) ? 1'b1 : !((c % 4 == 1) || (c % 4 == 2));
            if (fwait == 0) begin
                fmem_full = 1'b1;
            end else if (in_wait) begin
                fmem_full = (wait_cnt >= fwait);
                if (fmem_full && g_frise < 0) g_frise = c;
                wait_cnt++;
            end else if (conv_start) begin
                fmem_full = (c % 3 != 0);
            end else begin
                fmem_full = 1'b0;
            end
            #1;
            mv_h[c]  = m_valid;
            acc_h[c] = xmem_wr_en;
            if (xmem_wr_en) g_acc++;
            if (xmem_wr_en && !en_pline_stages) g_acc_not_en++;
            if (prev_stall && !m_valid) g_stall_viol++;
            prev_stall = m_valid && !m_ready;
            if (in_wait && (s_ready_x || m_valid || xmem_wr_en)) g_wait_viol++;
            if (conv_start && g_run_entry < 0) g_run_entry = c;
            if (m_valid && g_first_mv < 0) g_first_mv = c;
            if (m_valid && m_ready) begin
                g_hs++;
                g_last_hs = c;
            end
            if (conv_done) begin
                if (g_done_cnt < 2) begin
                    g_done_cyc[g_done_cnt]   = c;
                    g_hs_at_done[g_done_cnt] = g_hs;
                end
                if (xmem_wr_en || m_valid || s_ready_x) g_done_viol++;
                g_done_cnt++;
            end
            c++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (s_ready_x !== 1'b1) begin errors++; $display("FAIL reset_s_ready_x got %b exp 1", s_ready_x); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++;
        if (conv_start !== 1'b0) begin errors++; $display("FAIL reset_conv_start got %b exp 0", conv_start); end
        checks++;
        if (xmem_full !== 1'b0) begin errors++; $display("FAIL reset_xmem_full got %b exp 0", xmem_full); end
        checks++;
        if (conv_done !== 1'b0) begin errors++; $display("FAIL reset_conv_done got %b exp 0", conv_done); end
        checks++;
        if (en_pline_stages !== 1'b1) begin errors++; $display("FAIL reset_en_pline got %b exp 1", en_pline_stages); end
        checks++;
    endtask

    task automatic test_stream();
        do_reset();
        run_vec(0, 0, 0, 1, 400);
        if (g_done_cnt !== 1) begin errors++; $display("FAIL stream_done_count got %0d exp 1", g_done_cnt); end
        checks++;
        if (g_acc !== 128) begin errors++; $display("FAIL stream_accepts got %0d exp 128", g_acc); end
        checks++;
        if (g_hs !== 97) begin errors++; $display("FAIL stream_handshakes got %0d exp 97", g_hs); end
        checks++;
        if (g_run_entry !== 33) begin errors++; $display("FAIL stream_run_entry got %0d exp 33", g_run_entry); end
        checks++;
        if (g_first_mv !== 36) begin errors++; $display("FAIL stream_first_m_valid got %0d exp 36", g_first_mv); end
        checks++;
        if (g_last_hs !== 132) begin errors++; $display("FAIL stream_last_hs got %0d exp 132", g_last_hs); end
        checks++;
        if (g_done_cyc[0] !== 133) begin errors++; $display("FAIL stream_done_cycle got %0d exp 133", g_done_cyc[0]); end
        checks++;
        if (g_done_viol !== 0) begin errors++; $display("FAIL stream_done_outputs got %0d exp 0", g_done_viol); end
        checks++;
        if (s_ready_x !== 1'b1) begin errors++; $display("FAIL stream_refill_ready got %b exp 1", s_ready_x); end
        checks++;
    endtask

    task automatic test_wait_fmem();
        do_reset();
        run_vec(0, 0, 50, 1, 600);
        if (g_wait_viol !== 0) begin errors++; $display("FAIL wait_outputs got %0d exp 0", g_wait_viol); end
        checks++;
        if (g_frise !== 82) begin errors++; $display("FAIL wait_fmem_rise got %0d exp 82", g_frise); end
        checks++;
        if (g_run_entry !== 83) begin errors++; $display("FAIL wait_run_entry got %0d exp 83", g_run_entry); end
        checks++;
        if (g_hs !== 97) begin errors++; $display("FAIL wait_handshakes got %0d exp 97", g_hs); end
        checks++;
        if (g_done_cnt !== 1) begin errors++; $display("FAIL wait_done_count got %0d exp 1", g_done_cnt); end
        checks++;
    endtask

    task automatic test_backpressure();
        do_reset();
        run_vec(0, 1, 0, 1, 2000);
        if (g_hs !== 97) begin errors++; $display("FAIL bp_handshakes got %0d exp 97", g_hs); end
        checks++;
        if (g_acc !== 128) begin errors++; $display("FAIL bp_accepts got %0d exp 128", g_acc); end
        checks++;
        if (g_stall_viol !== 0) begin errors++; $display("FAIL bp_m_valid_dropped got %0d exp 0", g_stall_viol); end
        checks++;
        if (g_acc_not_en !== 0) begin errors++; $display("FAIL bp_accept_while_stalled got %0d exp 0", g_acc_not_en); end
        checks++;
        if (g_done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got %0d exp 1", g_done_cnt); end
        checks++;
        if (g_done_cyc[0] !== g_last_hs + 1) begin
            errors++; $display("FAIL bp_done_cycle got %0d exp %0d", g_done_cyc[0], g_last_hs + 1);
        end
        checks++;
    endtask

    task automatic test_sparse_input();
        int gaps;
        do_reset();
        run_vec(1, 0, 0, 1, 2000);
        gaps = 0;
        if (g_run_entry >= 0 && g_done_cyc[0] > 0) begin
            for (int c = g_run_entry + 4; c < g_done_cyc[0]; c++) begin
                if (mv_h[c] != acc_h[c-4]) gaps++;
            end
        end
        if (g_done_cnt !== 1) begin errors++; $display("FAIL sparse_done_count got %0d exp 1", g_done_cnt); end
        checks++;
        if (g_hs !== 97) begin errors++; $display("FAIL sparse_handshakes got %0d exp 97", g_hs); end
        checks++;
        if (g_acc !== 128) begin errors++; $display("FAIL sparse_accepts got %0d exp 128", g_acc); end
        checks++;
        if (g_first_mv !== g_run_entry + 3) begin
            errors++; $display("FAIL sparse_first_m_valid got %0d exp %0d", g_first_mv, g_run_entry + 3);
        end
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL sparse_gap_pattern got %0d exp 0", gaps); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int hs;
        int dn;
        int c;
        do_reset();
        hs = 0; dn = 0; c = 0;
        while (hs < 40 && c < 300) begin
            s_valid_x = 1'b1; m_ready = 1'b1; fmem_full = 1'b1;
            #1;
            if (m_valid && m_ready) hs++;
            if (conv_done) dn++;
            c++;
            @(posedge clk);
            #1;
        end
        if (hs !== 40) begin errors++; $display("FAIL rstmid_reach_40 got %0d exp 40", hs); end
        checks++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_valid_x = 1'b0;
        #1;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got %b exp 0", m_valid); end
        checks++;
        if (s_ready_x !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready_x got %b exp 1", s_ready_x); end
        checks++;
        if (conv_start !== 1'b0) begin errors++; $display("FAIL rstmid_conv_start got %b exp 0", conv_start); end
        checks++;
        for (int i = 0; i < 20; i++) begin
            if (conv_done) dn++;
            @(posedge clk);
            #1;
        end
        if (dn !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", dn); end
        checks++;
        run_vec(0, 0, 0, 1, 400);
        if (g_run_entry !== 33) begin errors++; $display("FAIL rstmid_rerun_entry got %0d exp 33", g_run_entry); end
        checks++;
        if (g_hs !== 97) begin errors++; $display("FAIL rstmid_rerun_handshakes got %0d exp 97", g_hs); end
        checks++;
        if (g_done_cnt !== 1) begin errors++; $display("FAIL rstmid_rerun_done got %0d exp 1", g_done_cnt); end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_vec(0, 0, 0, 2, 800);
        if (g_done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", g_done_cnt); end
        checks++;
        if (g_hs !== 194) begin errors++; $display("FAIL b2b_handshakes got %0d exp 194", g_hs); end
        checks++;
        if (g_acc !== 256) begin errors++; $display("FAIL b2b_accepts got %0d exp 256", g_acc); end
        checks++;
        if (g_hs_at_done[0] !== 97) begin errors++; $display("FAIL b2b_first_outputs got %0d exp 97", g_hs_at_done[0]); end
        checks++;
        if (g_done_cyc[1] !== 267) begin errors++; $display("FAIL b2b_second_done got %0d exp 267", g_done_cyc[1]); end
        checks++;
        if (g_done_viol !== 0) begin errors++; $display("FAIL b2b_accept_in_done got %0d exp 0", g_done_viol); end
        checks++;
        if (acc_h[134] !== 1'b1) begin errors++; $display("FAIL b2b_refill_start got %b exp 1", acc_h[134]); end
        checks++;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        s_valid_x = 1'b0;
        m_ready   = 1'b0;
        fmem_full = 1'b0;
        test_reset();
        test_stream();
        test_wait_fmem();
        test_backpressure();
        test_sparse_input();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
